// File: rtl/bus_responder_pkg.sv
// Shared definitions for the bus responder: bus widths, the address map,
// timer register offsets, the timer control layout and the address decoder.
package bus_responder_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  // Region codes carried in addr[15:12]
  localparam logic [3:0] REGION_RAM = 4'h0;
  localparam logic [3:0] REGION_LED = 4'h1;
  localparam logic [3:0] REGION_SW  = 4'h3;
  localparam logic [3:0] REGION_TMR = 4'h4;

  // Timer register offsets carried in addr[1:0]
  localparam logic [1:0] TMR_LOAD  = 2'd0;
  localparam logic [1:0] TMR_CTRL  = 2'd1;
  localparam logic [1:0] TMR_STAT  = 2'd2;
  localparam logic [1:0] TMR_COUNT = 2'd3;

  typedef enum logic [2:0] {
    TGT_NONE,
    TGT_RAM,
    TGT_LED,
    TGT_SW,
    TGT_TMR
  } target_e;

  // Timer CTRL register: bit1 AUTO, bit0 EN
  typedef struct packed {
    logic auto_reload;
    logic en;
  } tmr_ctrl_t;

  // Map the region nibble of a bus address onto a target
  function automatic target_e decode(input logic [3:0] region);
    case (region)
      REGION_RAM: decode = TGT_RAM;
      REGION_LED: decode = TGT_LED;
      REGION_SW:  decode = TGT_SW;
      REGION_TMR: decode = TGT_TMR;
      default:    decode = TGT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bus_responder_if.sv
// Processor-side memory bus.
//   addr : bus address (master -> slave)
//   dout : write data  (master -> slave)
//   w    : write strobe (master -> slave)
//   din  : read data, one cycle after addr (slave -> master)
interface bus_responder_if;
  import bus_responder_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dout;
  logic              w;
  logic [DATA_W-1:0] din;

  modport master (output addr, output dout, output w, input din);
  modport slave  (input addr, input dout, input w, output din);
endinterface

// File: rtl/bus_responder_sync_ram.sv
// Single-port synchronous RAM, read-first, registered read data.
//   clk/rst_n : clock, async active-low reset (clears the read register only)
//   we        : write enable
//   addr      : word address
//   wdata     : write data
//   rdata     : registered read data (old contents on a same-word write)
module bus_responder_sync_ram #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Array contents are never cleared; holding reset also blocks writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else begin
      rdata <= mem[addr];
      if (we) begin
        mem[addr] <= wdata;
      end
    end
  end

endmodule

// File: rtl/bus_responder.sv
// Memory-side responder for the processor bus: decodes RAM, LED register,
// synchronised switches and an interval timer; read data returns on din
// one cycle after the address.
//   clock, resetn : system clock, async active-low reset
//   bus           : addr/dout/w in, din out
//   sw            : asynchronous switch inputs
//   ledr          : LED register
//   timer_irq     : timer expired flag
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter int unsigned RAM_AW = 8,
  parameter int unsigned LED_W  = 10,
  parameter int unsigned SW_W   = 10
) (
  input  logic             clock,
  input  logic             resetn,
  bus_responder_if.slave   bus,
  input  logic [SW_W-1:0]  sw,
  output logic [LED_W-1:0] ledr,
  output logic             timer_irq
);

  target_e           tgt;
  logic [1:0]        tmr_off;
  logic              wr_ram, wr_led, wr_load, wr_ctrl, wr_stat;

  logic [DATA_W-1:0] ram_rdata;
  logic [SW_W-1:0]   sw_meta, sw_sync;

  logic [DATA_W-1:0] tmr_load, tmr_count;
  tmr_ctrl_t         tmr_ctrl;
  logic              tmr_exp;
  logic              expire;
  logic [DATA_W-1:0] load_d, count_d;
  tmr_ctrl_t         ctrl_d;
  logic              exp_d;

  logic [DATA_W-1:0] rd_c;
  logic [DATA_W-1:0] rd_q;
  logic              sel_ram_q;

  // Middle address bits are only partially decoded
  logic unused_addr;
  assign unused_addr = ^bus.addr[11:2];

  // Decode and write strobes
  assign tgt     = decode(bus.addr[15:12]);
  assign tmr_off = bus.addr[1:0];
  assign wr_ram  = bus.w && (tgt == TGT_RAM);
  assign wr_led  = bus.w && (tgt == TGT_LED);
  assign wr_load = bus.w && (tgt == TGT_TMR) && (tmr_off == TMR_LOAD);
  assign wr_ctrl = bus.w && (tgt == TGT_TMR) && (tmr_off == TMR_CTRL);
  assign wr_stat = bus.w && (tgt == TGT_TMR) && (tmr_off == TMR_STAT);

  // Upper offset bits are ignored, so RAM aliases across its region
  bus_responder_sync_ram #(
    .AW (RAM_AW),
    .DW (DATA_W)
  ) u_ram (
    .clk   (clock),
    .rst_n (resetn),
    .we    (wr_ram),
    .addr  (bus.addr[RAM_AW-1:0]),
    .wdata (bus.dout),
    .rdata (ram_rdata)
  );

  // Two-flop switch synchroniser
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  // LED register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ledr <= '0;
    end else if (wr_led) begin
      ledr <= bus.dout[LED_W-1:0];
    end
  end

  // Timer next state; bus writes are applied last so they take priority,
  // except that an expiry keeps EXP set against a STAT write.
  assign expire = tmr_ctrl.en && (tmr_count == '0);

  always_comb begin
    load_d  = tmr_load;
    count_d = tmr_count;
    ctrl_d  = tmr_ctrl;
    exp_d   = tmr_exp;
    if (expire) begin
      exp_d = 1'b1;
      if (tmr_ctrl.auto_reload) begin
        count_d = tmr_load;
      end else begin
        ctrl_d.en = 1'b0;
      end
    end else if (tmr_ctrl.en) begin
      count_d = tmr_count - 16'd1;
    end
    if (wr_stat && !expire) begin
      exp_d = 1'b0;
    end
    if (wr_ctrl) begin
      ctrl_d = tmr_ctrl_t'(bus.dout[1:0]);
    end
    if (wr_load) begin
      load_d  = bus.dout;
      count_d = bus.dout;
    end
  end

  // Timer registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tmr_load  <= '0;
      tmr_count <= '0;
      tmr_ctrl  <= '0;
      tmr_exp   <= 1'b0;
    end else begin
      tmr_load  <= load_d;
      tmr_count <= count_d;
      tmr_ctrl  <= ctrl_d;
      tmr_exp   <= exp_d;
    end
  end

  assign timer_irq = tmr_exp;

  // Register-side read mux; samples state before this edge's update
  always_comb begin
    rd_c = '0;
    case (tgt)
      TGT_LED: rd_c = 16'(ledr);
      TGT_SW:  rd_c = 16'(sw_sync);
      TGT_TMR: begin
        case (tmr_off)
          TMR_LOAD:  rd_c = tmr_load;
          TMR_CTRL:  rd_c = 16'(tmr_ctrl);
          TMR_STAT:  rd_c = 16'(tmr_exp);
          TMR_COUNT: rd_c = tmr_count;
          default:   rd_c = '0;
        endcase
      end
      default: rd_c = '0;
    endcase
  end

  // Read data register; RAM data is already registered inside the RAM
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_q      <= '0;
      sel_ram_q <= 1'b0;
    end else begin
      rd_q      <= rd_c;
      sel_ram_q <= (tgt == TGT_RAM);
    end
  end

  assign bus.din = sel_ram_q ? ram_rdata : rd_q;

endmodule
